// File: rtl/draw_field.sv
// draw_field: renders the whole velocity-arrow field into the draw framebuffer
// in a single start/done transaction.
//
// The frame is scanned as a GRID_W x GRID_H array of BLOCK_SIZE-pixel blocks.
// For each block, the unit vector and magnitude are fetched from the vector store.
// Every pixel of the block is then tested against the arrow segment, and a
// framebuffer write is issued for it when required.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a frame (sampled in IDLE only)
//   clear_mode        1: write every pixel, 0: write on-line pixels only
//   busy, done        transaction status, done is a one-cycle pulse
//   vec_req/vec_addr  one-cycle read request to the vector store
//   vec_valid, vec_*  vector store response (Q16.16)
//   draw_*            registered framebuffer write port
module draw_field #(
   parameter int DRAW_WIDTH  = 320,
   parameter int DRAW_HEIGHT = 240,
   parameter int DRAW_ADDRW  = $clog2(DRAW_WIDTH*DRAW_HEIGHT),
   parameter int DRAW_DATAW  = 1,
   parameter int BLOCK_SIZE  = 40,
   parameter int GRID_W      = DRAW_WIDTH/BLOCK_SIZE,
   parameter int GRID_H      = DRAW_HEIGHT/BLOCK_SIZE,
   parameter int VEC_ADDRW   = $clog2(GRID_W*GRID_H)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  clear_mode,
   output logic                  busy,
   output logic                  done,
   output logic                  vec_req,
   output logic [VEC_ADDRW-1:0]  vec_addr,
   input  logic                  vec_valid,
   input  logic signed [31:0]    vec_xn,
   input  logic signed [31:0]    vec_yn,
   input  logic [31:0]           vec_mag,
   output logic [DRAW_ADDRW-1:0] draw_addr_write,
   output logic [DRAW_DATAW-1:0] draw_data_in,
   output logic                  draw_we
);

   localparam int PW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
   localparam int CW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam int RW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam logic [15:0] MAX_COLOUR = 16'((1 << DRAW_DATAW) - 1);
   localparam logic signed [31:0] HALF_BLK = 32'((BLOCK_SIZE/2) << 16);
   // Half a pixel expressed in Q32.32, the scale of the product terms below.
   localparam logic signed [63:0] HALF_PIX = 64'sh0000_0000_8000_0000;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAW, S_NEXT, S_FIN} state_t;

   // Integer part of the magnitude, clamped to the pixel range, never 0.
   function automatic logic [DRAW_DATAW-1:0] sat_colour(input logic [15:0] mag_int);
      logic [15:0] c;
      c = mag_int;
      if (c > MAX_COLOUR) c = MAX_COLOUR;
      if (c == 16'd0) c = 16'd1;
      return DRAW_DATAW'(c);
   endfunction

   // (n * mag) / 2 in Q16.16, rounded towards minus infinity.
   function automatic logic signed [31:0] half_span(input logic signed [31:0] n,
                                                    input logic [31:0] mag);
      logic signed [64:0] p;
      p = n * $signed({1'b0, mag});
      return 32'(p >>> 17);
   endfunction

   state_t state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [PW-1:0] x_q, x_d, y_q, y_d;
   logic clear_q, clear_d;
   logic signed [31:0] xn_q, xn_d, yn_q, yn_d, x0_q, x0_d, y0_q, y0_d;
   logic [31:0] mag_q, mag_d;
   logic draw_we_q, draw_we_d;
   logic [DRAW_ADDRW-1:0] draw_addr_q, draw_addr_d;
   logic [DRAW_DATAW-1:0] draw_data_q, draw_data_d;

   logic signed [31:0] dx, dy;
   logic signed [63:0] along, perp, perp_abs, mag_lim;
   logic on_line;

   // pixel_on_line: the arrow runs from (x0,y0) for mag pixels along (xn,yn);
   // a pixel is on it when its projection lies within the segment and its
   // perpendicular distance is at most half a pixel.
   always_comb begin
      dx       = (signed'(32'(x_q)) <<< 16) - x0_q;
      dy       = (signed'(32'(y_q)) <<< 16) - y0_q;
      along    = 64'(dx) * 64'(xn_q) + 64'(dy) * 64'(yn_q);
      perp     = 64'(dx) * 64'(yn_q) - 64'(dy) * 64'(xn_q);
      perp_abs = (perp < 0) ? -perp : perp;
      mag_lim  = signed'({16'h0, mag_q, 16'h0});
      on_line  = (along >= 0) && (along <= mag_lim) && (perp_abs <= HALF_PIX);
   end

   // State register and control counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         clear_q <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         x_q     <= x_d;
         y_q     <= y_d;
         clear_q <= clear_d;
      end
   end

   // Latched vector data: only meaningful once fetched, so not reset.
   always_ff @(posedge clk) begin
      xn_q  <= xn_d;
      yn_q  <= yn_d;
      mag_q <= mag_d;
      x0_q  <= x0_d;
      y0_q  <= y0_d;
   end

   // Next-state and counter logic.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      x_d     = x_q;
      y_d     = y_q;
      clear_d = clear_q;
      xn_d    = xn_q;
      yn_d    = yn_q;
      mag_d   = mag_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            clear_d = clear_mode;
            row_d   = '0;
            col_d   = '0;
            state_d = S_REQ;
         end
         S_REQ: state_d = S_WAIT;
         S_WAIT: if (vec_valid) begin
            xn_d  = vec_xn;
            yn_d  = vec_yn;
            mag_d = vec_mag;
            x0_d  = HALF_BLK - half_span(vec_xn, vec_mag);
            y0_d  = HALF_BLK - half_span(vec_yn, vec_mag);
            x_d   = '0;
            y_d   = '0;
            state_d = (vec_mag == 32'd0 && !clear_q) ? S_NEXT : S_DRAW;
         end
         S_DRAW: begin
            if (x_q == PW'(BLOCK_SIZE-1)) begin
               x_d = '0;
               if (y_q == PW'(BLOCK_SIZE-1)) state_d = S_NEXT;
               else y_d = y_q + PW'(1);
            end else begin
               x_d = x_q + PW'(1);
            end
         end
         S_NEXT: begin
            state_d = S_REQ;
            if (col_q == CW'(GRID_W-1)) begin
               col_d = '0;
               if (row_q == RW'(GRID_H-1)) begin
                  row_d   = '0;
                  state_d = S_FIN;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy     = (state_q != S_IDLE) && (state_q != S_FIN);
      done     = (state_q == S_FIN);
      vec_req  = (state_q == S_REQ);
      vec_addr = VEC_ADDRW'(32'(row_q) * GRID_W + 32'(col_q));
   end

   // Pixel write for the current pixel, presented one cycle later.
   always_comb begin
      draw_we_d   = 1'b0;
      draw_addr_d = draw_addr_q;
      draw_data_d = '0;
      if (state_q == S_DRAW) begin
         draw_we_d   = clear_q | on_line;
         draw_addr_d = DRAW_ADDRW'((32'(row_q) * BLOCK_SIZE + 32'(y_q)) * DRAW_WIDTH
                                   + 32'(col_q) * BLOCK_SIZE + 32'(x_q));
         draw_data_d = on_line ? sat_colour(mag_q[31:16]) : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         draw_we_q   <= 1'b0;
         draw_addr_q <= '0;
         draw_data_q <= '0;
      end else begin
         draw_we_q   <= draw_we_d;
         draw_addr_q <= draw_addr_d;
         draw_data_q <= draw_data_d;
      end
   end

   assign draw_we         = draw_we_q;
   assign draw_addr_write = draw_addr_q;
   assign draw_data_in    = draw_data_q;

endmodule

// File: tb/tb_draw_field.sv
module tb_draw_field;
   localparam int DW   = 64;
   localparam int DH   = 48;
   localparam int BS   = 16;
   localparam int DDW  = 4;
   localparam int GW   = DW/BS;
   localparam int GH   = DH/BS;
   localparam int NBLK = GW*GH;
   localparam int NPIX = DW*DH;
   localparam int AW   = $clog2(NPIX);
   localparam int VW   = $clog2(NBLK);

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, clear_mode = 1'b0;
   logic busy, done, vec_req, draw_we, vec_valid = 1'b0;
   logic [VW-1:0] vec_addr;
   logic signed [31:0] vec_xn = '0, vec_yn = '0;
   logic [31:0] vec_mag = '0;
   logic [AW-1:0] draw_addr_write;
   logic [DDW-1:0] draw_data_in;

   draw_field #(.DRAW_WIDTH(DW), .DRAW_HEIGHT(DH), .DRAW_DATAW(DDW), .BLOCK_SIZE(BS)) dut (
      .clk(clk), .rst(rst), .start(start), .clear_mode(clear_mode),
      .busy(busy), .done(done), .vec_req(vec_req), .vec_addr(vec_addr),
      .vec_valid(vec_valid), .vec_xn(vec_xn), .vec_yn(vec_yn), .vec_mag(vec_mag),
      .draw_addr_write(draw_addr_write), .draw_data_in(draw_data_in), .draw_we(draw_we));

   always #5 clk = ~clk;

   int n_tot = 0, n_bad = 0;
   int cyc = 0;
   int vxn[NBLK], vyn[NBLK];
   logic [31:0] vmag[NBLK];
   int wr_cnt[4096];
   int img[4096];
   int exp_wr[NPIX];
   int exp_img[NPIX];
   int exp_n;
   int n_wr, done_cnt, last_wr_cyc, done_cyc, vreq_dbl;
   logic vreq_prev = 1'b0;
   int req_addrs[$];
   int lat_fix = 1;
   bit lat_rand = 0, stray_en = 0;
   int dir_tab[8][2] = '{'{65536, 0}, '{0, 65536}, '{-65536, 0}, '{0, -65536},
                         '{39322, 52429}, '{-52429, 39322}, '{46341, 46341}, '{46341, -46341}};

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_tot++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Write/handshake monitor.
   initial forever begin
      @(negedge clk);
      if (draw_we) begin
         wr_cnt[draw_addr_write]++;
         img[draw_addr_write] = int'(draw_data_in);
         n_wr++;
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (vec_req && vreq_prev) vreq_dbl++;
      vreq_prev = vec_req;
   end

   // Vector store with programmable latency and stray valid pulses.
   initial forever begin
      @(negedge clk);
      vec_valid = 1'b0;
      if (vec_req) begin
         automatic int a = int'(vec_addr);
         automatic int lat = lat_rand ? int'($urandom_range(1, 7)) : lat_fix;
         req_addrs.push_back(a);
         repeat (lat) @(negedge clk);
         vec_valid = 1'b1;
         vec_xn  = vxn[a % NBLK];
         vec_yn  = vyn[a % NBLK];
         vec_mag = vmag[a % NBLK];
      end else if (stray_en && ($urandom_range(0, 15) == 0)) begin
         vec_valid = 1'b1;
         vec_xn  = $urandom;
         vec_yn  = $urandom;
         vec_mag = $urandom;
      end
   end

   function automatic bit model_on(int xn, int yn, logic [31:0] m, int x, int y);
      longint mag, x0, y0, dx, dy, along, perp;
      mag   = longint'(m);
      x0    = longint'(BS/2) * 65536 - ((longint'(xn) * mag) >>> 17);
      y0    = longint'(BS/2) * 65536 - ((longint'(yn) * mag) >>> 17);
      dx    = longint'(x) * 65536 - x0;
      dy    = longint'(y) * 65536 - y0;
      along = dx * xn + dy * yn;
      perp  = dx * yn - dy * xn;
      if (perp < 0) perp = -perp;
      return (along >= 0) && (along <= mag * 65536) && (perp <= (longint'(1) << 31));
   endfunction

   function automatic int model_colour(logic [31:0] m);
      int c;
      c = int'(m >> 16);
      if (c > (1 << DDW) - 1) c = (1 << DDW) - 1;
      if (c < 1) c = 1;
      return c;
   endfunction

   task automatic build_model(input bit clr);
      exp_n = 0;
      for (int i = 0; i < NPIX; i++) begin
         exp_wr[i] = 0;
         exp_img[i] = 0;
      end
      for (int b = 0; b < NBLK; b++) begin
         if (vmag[b] == 0 && !clr) continue;
         for (int y = 0; y < BS; y++)
            for (int x = 0; x < BS; x++) begin
               automatic int a = ((b / GW) * BS + y) * DW + (b % GW) * BS + x;
               automatic bit on = model_on(vxn[b], vyn[b], vmag[b], x, y);
               if (clr || on) begin
                  exp_wr[a] = 1;
                  exp_img[a] = on ? model_colour(vmag[b]) : 0;
                  exp_n++;
               end
            end
      end
   endtask

   task automatic clear_sb();
      for (int i = 0; i < 4096; i++) begin
         wr_cnt[i] = 0;
         img[i] = 0;
      end
      n_wr = 0; done_cnt = 0; last_wr_cyc = 0; done_cyc = 0; vreq_dbl = 0;
      req_addrs.delete();
   endtask

   task automatic start_frame(input bit clr);
      @(negedge clk);
      clear_mode = clr;
      start = 1'b1;
      @(posedge clk);
      #1 chk("busy_after_start", longint'(busy), 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input bit disturb);
      bit ok = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
         if (disturb) begin
            start = 1'($urandom_range(0, 1));
            clear_mode = 1'($urandom_range(0, 1));
         end
      end
      start = 1'b0;
      if (!ok) chk("done_timeout", 0, 1);
   endtask

   task automatic check_frame();
      int pix_bad = 0, wr_bad = 0, ord_bad = 0;
      repeat (10) @(negedge clk);
      chk("busy_after_done", longint'(busy), 0);
      chk("done_count", done_cnt, 1);
      chk("write_count", n_wr, exp_n);
      chk("last_write_before_done", longint'(last_wr_cyc < done_cyc), 1);
      for (int i = 0; i < NPIX; i++) begin
         if (wr_cnt[i] != exp_wr[i]) wr_bad++;
         if (exp_wr[i] != 0 && img[i] != exp_img[i]) pix_bad++;
      end
      chk("addr_write_counts", wr_bad, 0);
      chk("pixel_data", pix_bad, 0);
      chk("vec_req_count", req_addrs.size(), NBLK);
      for (int i = 0; i < req_addrs.size(); i++)
         if (req_addrs[i] != i) ord_bad++;
      chk("vec_addr_order", ord_bad, 0);
      chk("vec_req_single_cycle", vreq_dbl, 0);
   endtask

   task automatic run_frame(input bit clr, input bit disturb);
      clear_sb();
      build_model(clr);
      start_frame(clr);
      wait_done(disturb);
      check_frame();
   endtask

   task automatic set_uniform(input logic [31:0] m);
      for (int b = 0; b < NBLK; b++) begin
         vxn[b] = 65536; vyn[b] = 0; vmag[b] = m;
      end
   endtask

   task automatic set_random();
      for (int b = 0; b < NBLK; b++) begin
         automatic int d = int'($urandom_range(0, 7));
         vxn[b] = dir_tab[d][0];
         vyn[b] = dir_tab[d][1];
         vmag[b] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 14 << 16));
      end
   endtask

   initial begin
      #12;
      chk("reset_outputs", longint'({busy, done, vec_req, draw_we, draw_data_in,
                                     draw_addr_write, vec_addr}), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Full clear frame, every pixel written once.
      set_uniform(32'h0000_8000);
      run_frame(1, 0);
      chk("full_frame_writes", n_wr, NPIX);

      // Single horizontal arrow in block (1,1), overlay mode.
      set_uniform(32'd0);
      vmag[GW + 1] = 32'd8 << 16;
      run_frame(0, 0);
      chk("arrow_writes", n_wr, 9);
      chk("arrow_first", wr_cnt[1556], 1);
      chk("arrow_last", wr_cnt[1564], 1);
      chk("arrow_before", wr_cnt[1555], 0);
      chk("arrow_after", wr_cnt[1565], 0);
      chk("arrow_colour", img[1560], 8);

      // Colour saturation and the minimum colour of 1.
      set_uniform(32'd0);
      vmag[0] = 32'd40 << 16;
      vmag[1] = 32'h0000_4000;
      run_frame(1, 0);
      chk("sat_colour", img[512], 15);
      chk("min_colour", img[536], 1);
      chk("off_line_zero", img[535], 0);

      // Start pulses and clear_mode changes while busy.
      set_random();
      run_frame(1, 1);
      set_random();
      run_frame(0, 1);

      // Reset during block 3 drawing.
      set_uniform(32'h0000_8000);
      clear_sb();
      start_frame(1);
      for (int i = 0; i < 3000 && req_addrs.size() < 4; i++) @(negedge clk);
      chk("reached_block3", req_addrs.size(), 4);
      repeat (30) @(negedge clk);
      chk("pre_reset_we", longint'(draw_we), 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1 chk("reset_we", longint'(draw_we), 0);
      chk("reset_busy", longint'(busy), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_done_after_reset", done_cnt, 0);
      run_frame(1, 0);

      // Vector latency 5, then random latency with stray valid pulses.
      lat_fix = 5;
      run_frame(1, 0);
      lat_rand = 1;
      stray_en = 1;
      run_frame(1, 0);
      for (int k = 0; k < 3; k++) begin
         set_random();
         run_frame(1'($urandom_range(0, 1)), 0);
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end
endmodule
